// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the IF/LSU memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 3;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} owner_e;
    typedef enum logic {LSU_PRIO, IF_PRIO} prio_e;

    function automatic int cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: counts consecutive IF denials, saturating, and flags when the limit is reached.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter  int LIMIT = DEF_STARVE_LIMIT,
    localparam int W     = cnt_w(LIMIT)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic lsu_gnt_i,
    output logic limit_hit_o
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    // A served or withdrawn IF request ends the starvation streak.
    assign cnt_d = (if_gnt_i || !if_req_i) ? '0 :
                   (lsu_gnt_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;

    assign limit_hit_o = (cnt_d == LIM);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency single-port SRAM between instruction fetch and the LSU,
// LSU-first with a starvation override that gives IF one guaranteed grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W       = DEF_ADDR_W,
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [BE_W-1:0]   lsu_be_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    prio_e  state_q, state_d;
    owner_e resp_q, resp_d;
    logic   resp_we_q, resp_we_d;
    logic   limit_hit;

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_gnt_i    (if_gnt_o),
        .lsu_gnt_i   (lsu_gnt_o),
        .limit_hit_o (limit_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= LSU_PRIO;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == LSU_PRIO) ? (limit_hit ? IF_PRIO : LSU_PRIO)
                                        : ((if_gnt_o || !if_req_i) ? LSU_PRIO : IF_PRIO);
    end

    always_comb begin
        lsu_gnt_o   = lsu_req_i && (state_q == LSU_PRIO || !if_req_i);
        if_gnt_o    = if_req_i && !lsu_gnt_o;
        mem_req_o   = if_gnt_o || lsu_gnt_o;
        mem_we_o    = lsu_gnt_o && lsu_we_i;
        mem_addr_o  = lsu_gnt_o ? lsu_addr_i : (if_gnt_o ? if_addr_i : '0);
        mem_be_o    = mem_we_o ? lsu_be_i : '0;
        mem_wdata_o = mem_we_o ? lsu_wdata_i : '0;
    end

    // Response owner tracks the grant one cycle back, matching the SRAM read latency.
    assign resp_d    = lsu_gnt_o ? OWN_LSU : (if_gnt_o ? OWN_IF : OWN_NONE);
    assign resp_we_d = lsu_gnt_o && lsu_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q    <= OWN_NONE;
            resp_we_q <= 1'b0;
        end else begin
            resp_q    <= resp_d;
            resp_we_q <= resp_we_d;
        end
    end

    assign if_rvalid_o  = (resp_q == OWN_IF);
    assign lsu_rvalid_o = (resp_q == OWN_LSU);
    assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
    assign lsu_rdata_o  = (lsu_rvalid_o && !resp_we_q) ? mem_rdata_i : '0;

endmodule
